// File: rtl/key_event_fifo_if.sv
// rtl/key_event_fifo_if.sv - key capture and consumer handshake bundle for key_event_fifo
interface key_event_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_valid;
  logic [3:0]    key_code;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_code;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output key_valid, key_code, clear, out_ready,
    input  out_valid, out_code, count, overflow
  );

  modport slave (
    input  key_valid, key_code, clear, out_ready,
    output out_valid, out_code, count, overflow
  );
endinterface

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keypad repeat filter feeding a show-ahead key code FIFO
module key_event_fifo #(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 16
) (
  input  logic             clock,
  input  logic             reset,
  key_event_fifo_if.slave  bus
);
  localparam int         AW     = $clog2(DEPTH);
  localparam int         CW     = AW + 1;
  localparam logic [7:0] RELOAD = 8'(HOLDOFF - 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e        state_q, state_d;
  logic [3:0]    last_code_q, last_code_d;
  logic [7:0]    timer_q, timer_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    mem_q [DEPTH];

  logic push_req, push_ok, pop, full;

  always_comb begin
    state_d     = state_q;
    last_code_d = last_code_q;
    timer_d     = timer_q;
    push_req    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          push_req    = 1'b1;
          last_code_d = bus.key_code;
          timer_d     = RELOAD;
          state_d     = LOCK;
        end
      end
      LOCK: begin
        if (bus.key_valid) begin
          timer_d = RELOAD;
          if (bus.key_code != last_code_q) begin
            push_req    = 1'b1;
            last_code_d = bus.key_code;
          end
        end else if (timer_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    full       = (count_q == CW'(DEPTH));
    pop        = (count_q != '0) && bus.out_ready;
    push_ok    = push_req && (!full || pop);
    overflow_d = overflow_q | (push_req && full && !pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    if (bus.clear) begin
      state_d     = IDLE;
      last_code_d = last_code_q;
      timer_d     = 8'd0;
      push_ok     = 1'b0;
      pop         = 1'b0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_code_q <= 4'h0;
      timer_q     <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_code_q <= last_code_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is never reset; out_code is masked while empty instead.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.key_code;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_code  = (count_q != '0) ? mem_q[rd_ptr_q] : 4'h0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule
